// File: rtl/axi_arb_pkg.sv
// Shared constants and width helpers for the AXI read arbiter.
package axi_arb_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic int port_idx_w(input int num_ports);
    return $clog2(num_ports);
  endfunction

  function automatic int cnt_w(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/axi_bus_rd_t.sv
// AXI4 read-only bus: AR and R channels with master/slave views.
interface axi_bus_rd_t #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
);
  logic [ADDR_W-1:0] araddr;
  logic [1:0]        arburst;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [ID_W-1:0]   arid;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arburst, arlen, arsize, arid, arvalid, rready,
    input  arready, rdata, rresp, rlast, rid, rvalid
  );

  modport slave (
    input  araddr, arburst, arlen, arsize, arid, arvalid, rready,
    output arready, rdata, rresp, rlast, rid, rvalid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after rr_ptr, wrapping,
// and moves the pointer past the winner when the grant is taken.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W    = port_idx_w(NUM_PORTS)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 adv_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 gnt_valid_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    int               p;
    logic [IDX_W-1:0] p_idx;
    logic             found;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = int'(rr_ptr_q) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      p_idx = IDX_W'(p);
      if (!found && req_i[p_idx]) begin
        found        = 1'b1;
        gnt_o[p_idx] = 1'b1;
        gnt_idx_o    = p_idx;
      end
    end
    gnt_valid_o = found;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv_i && gnt_valid_o) begin
      rr_ptr_d = (gnt_idx_o == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) rr_ptr_q <= '0;
    else           rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master among NUM_PORTS requesters: round-robin AR grant
// into a one-entry register tagged with the port index, R beats routed by rid.
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_PORTS        = 4,
  parameter int M_AXI_ADDR_WIDTH = 64,
  parameter int M_AXI_DATA_WIDTH = 512,
  parameter int M_AXI_ID_WIDTH   = 4,
  parameter int MAX_OUTSTANDING  = 16
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  axi_bus_rd_t.slave  s_axi [NUM_PORTS],
  axi_bus_rd_t.master m_axi,
  output logic        busy,
  output logic        err_bad_rid
);

  localparam int IDX_W = port_idx_w(NUM_PORTS);
  localparam int CNT_W = cnt_w(MAX_OUTSTANDING);

  typedef struct packed {
    logic                        valid;
    logic [M_AXI_ID_WIDTH-1:0]   id;
    logic [M_AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                  len;
    logic [2:0]                  size;
    logic [1:0]                  burst;
  } ar_reg_t;

  logic [NUM_PORTS-1:0]        s_arvalid, s_rready, elig, gnt_oh, ar_take, r_sel, r_done;
  logic [M_AXI_ADDR_WIDTH-1:0] s_araddr  [NUM_PORTS];
  logic [7:0]                  s_arlen   [NUM_PORTS];
  logic [2:0]                  s_arsize  [NUM_PORTS];
  logic [1:0]                  s_arburst [NUM_PORTS];
  logic [CNT_W-1:0]            cnt_q     [NUM_PORTS];
  logic [CNT_W-1:0]            cnt_d     [NUM_PORTS];
  logic [IDX_W-1:0]            gnt_idx, rid_idx;
  logic                        gnt_any, load_en, rid_ok, any_cnt;
  logic                        busy_q, busy_d, err_q, err_d;
  ar_reg_t                     ar_q, ar_d;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign s_arvalid[i] = s_axi[i].arvalid;
    assign s_araddr[i]  = s_axi[i].araddr;
    assign s_arlen[i]   = s_axi[i].arlen;
    assign s_arsize[i]  = s_axi[i].arsize;
    assign s_arburst[i] = s_axi[i].arburst;
    assign s_rready[i]  = s_axi[i].rready;
    assign elig[i]      = s_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    assign r_sel[i]     = m_axi.rvalid && rid_ok && (rid_idx == IDX_W'(i));

    assign s_axi[i].arready = ar_take[i];
    assign s_axi[i].rvalid  = r_sel[i];
    assign s_axi[i].rdata   = m_axi.rdata;
    assign s_axi[i].rresp   = m_axi.rresp;
    assign s_axi[i].rlast   = m_axi.rlast;
    assign s_axi[i].rid     = '0;
  end

  // Grant only while out of reset and the output slot is free or draining.
  assign load_en = ap_rst_n && (!ar_q.valid || m_axi.arready);
  assign ar_take = load_en ? gnt_oh : '0;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .req_i       (elig),
    .adv_i       (load_en),
    .gnt_o       (gnt_oh),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_any)
  );

  always_comb begin
    ar_d = ar_q;
    if (load_en) begin
      if (gnt_any) begin
        ar_d.valid = 1'b1;
        ar_d.id    = M_AXI_ID_WIDTH'(gnt_idx);
        ar_d.addr  = s_araddr[gnt_idx];
        ar_d.len   = s_arlen[gnt_idx];
        ar_d.size  = s_arsize[gnt_idx];
        ar_d.burst = s_arburst[gnt_idx];
      end else begin
        ar_d.valid = 1'b0;
      end
    end
  end

  assign m_axi.arvalid = ar_q.valid;
  assign m_axi.arid    = ar_q.id;
  assign m_axi.araddr  = ar_q.addr;
  assign m_axi.arlen   = ar_q.len;
  assign m_axi.arsize  = ar_q.size;
  assign m_axi.arburst = ar_q.burst;

  // The extra bit keeps the bound compare exact when NUM_PORTS == 2**ID width.
  assign rid_ok       = {1'b0, m_axi.rid} < (M_AXI_ID_WIDTH + 1)'(NUM_PORTS);
  assign rid_idx      = m_axi.rid[IDX_W-1:0];
  assign m_axi.rready = rid_ok ? s_rready[rid_idx] : 1'b1;
  assign r_done       = r_sel & s_rready & {NUM_PORTS{m_axi.rlast}};

  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({ar_take[i], r_done[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
      any_cnt = any_cnt | (cnt_q[i] != '0);
    end
  end

  assign busy_d = ar_q.valid || any_cnt;
  assign err_d  = err_q || (m_axi.rvalid && !rid_ok);

  // NOTE: the counters are reset too; in-flight bursts are abandoned with them.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ar_q   <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      ar_q   <= ar_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign busy        = busy_q;
  assign err_bad_rid = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed sequences, an R-routing
// vector table and randomized traffic against a cycle-level reference model.
module tb_axi_rd_arbiter;
  import axi_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MO = 2;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  // requester-side stimulus and observations
  logic [N-1:0]  s_arvalid, s_rready, s_arready, s_rvalid, s_rlast;
  logic [AW-1:0] s_araddr  [N];
  logic [7:0]    s_arlen   [N];
  logic [2:0]    s_arsize  [N];
  logic [1:0]    s_arburst [N];
  logic [DW-1:0] s_rdata   [N];
  logic [1:0]    s_rresp   [N];
  logic [IW-1:0] s_rid     [N];

  // memory-side stimulus and observations
  logic          m_arready, m_rvalid, m_rlast, m_arvalid, m_rready;
  logic [IW-1:0] m_rid, m_arid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp, m_arburst;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic          busy, err;

  axi_bus_rd_t #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) s_axi [N] ();
  axi_bus_rd_t #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) m_axi ();

  for (genvar i = 0; i < N; i++) begin : g_tb
    assign s_axi[i].arvalid = s_arvalid[i];
    assign s_axi[i].araddr  = s_araddr[i];
    assign s_axi[i].arlen   = s_arlen[i];
    assign s_axi[i].arsize  = s_arsize[i];
    assign s_axi[i].arburst = s_arburst[i];
    assign s_axi[i].arid    = '0;
    assign s_axi[i].rready  = s_rready[i];
    assign s_arready[i]     = s_axi[i].arready;
    assign s_rvalid[i]      = s_axi[i].rvalid;
    assign s_rlast[i]       = s_axi[i].rlast;
    assign s_rdata[i]       = s_axi[i].rdata;
    assign s_rresp[i]       = s_axi[i].rresp;
    assign s_rid[i]         = s_axi[i].rid;
  end

  assign m_axi.arready = m_arready;
  assign m_axi.rvalid  = m_rvalid;
  assign m_axi.rid     = m_rid;
  assign m_axi.rdata   = m_rdata;
  assign m_axi.rresp   = m_rresp;
  assign m_axi.rlast   = m_rlast;
  assign m_arvalid     = m_axi.arvalid;
  assign m_araddr      = m_axi.araddr;
  assign m_arlen       = m_axi.arlen;
  assign m_arsize      = m_axi.arsize;
  assign m_arburst     = m_axi.arburst;
  assign m_arid        = m_axi.arid;
  assign m_rready      = m_axi.rready;

  axi_rd_arbiter #(
    .NUM_PORTS(N), .M_AXI_ADDR_WIDTH(AW), .M_AXI_DATA_WIDTH(DW),
    .M_AXI_ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .s_axi       (s_axi),
    .m_axi       (m_axi),
    .busy        (busy),
    .err_bad_rid (err)
  );

  // Reference model: pending AR slot, round-robin pointer, bursts in flight per port.
  int            mdl_rr;
  bit            mdl_valid;
  logic [AW-1:0] mdl_addr;
  logic [7:0]    mdl_len;
  logic [2:0]    mdl_size;
  logic [1:0]    mdl_burst;
  int            mdl_id;
  int            mdl_cnt [N];
  bit            mdl_busy, mdl_err;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_rr = 0; mdl_valid = 0; mdl_addr = '0; mdl_len = '0; mdl_size = '0;
    mdl_burst = '0; mdl_id = 0; mdl_busy = 0; mdl_err = 0;
    for (int i = 0; i < N; i++) mdl_cnt[i] = 0;
  endtask

  function automatic int model_grant();
    int p;
    if (!ap_rst_n) return -1;
    if (mdl_valid && !m_arready) return -1;
    for (int k = 0; k < N; k++) begin
      p = (mdl_rr + k) % N;
      if (s_arvalid[p] && mdl_cnt[p] < MO) return p;
    end
    return -1;
  endfunction

  function automatic int dut_grant();
    int g = -1;
    for (int i = 0; i < N; i++) begin
      if (s_arready[i] === 1'b1) begin
        if (g != -1) return -2;
        g = i;
      end
    end
    return g;
  endfunction

  task automatic compare_all();
    int   g;
    logic exp_rv;
    logic exp_rr;
    g = model_grant();
    for (int i = 0; i < N; i++) begin
      check($sformatf("arready[%0d]", i), s_arready[i], (i == g));
      exp_rv = m_rvalid && (int'(m_rid) < N) && (int'(m_rid) == i);
      check($sformatf("rvalid[%0d]", i), s_rvalid[i], exp_rv);
      if (exp_rv) begin
        check($sformatf("rdata[%0d]", i), s_rdata[i], m_rdata);
        check($sformatf("rresp[%0d]", i), s_rresp[i], m_rresp);
        check($sformatf("rlast[%0d]", i), s_rlast[i], m_rlast);
      end
      check($sformatf("s_rid[%0d]", i), s_rid[i], 0);
    end
    if (int'(m_rid) < N) exp_rr = s_rready[m_rid];
    else                 exp_rr = 1'b1;
    check("m_rready", m_rready, exp_rr);
    check("m_arvalid", m_arvalid, mdl_valid);
    if (mdl_valid) begin
      check("m_araddr", m_araddr, mdl_addr);
      check("m_arlen", m_arlen, mdl_len);
      check("m_arsize", m_arsize, mdl_size);
      check("m_arburst", m_arburst, mdl_burst);
      check("m_arid", m_arid, mdl_id);
    end
    check("busy", busy, mdl_busy);
    check("err_bad_rid", err, mdl_err);
  endtask

  task automatic model_update();
    int g;
    bit busy_n;
    if (!ap_rst_n) begin
      model_reset();
      return;
    end
    g = model_grant();
    busy_n = mdl_valid;
    for (int i = 0; i < N; i++) if (mdl_cnt[i] != 0) busy_n = 1;
    if (m_rvalid && int'(m_rid) >= N) mdl_err = 1;
    if (m_rvalid && int'(m_rid) < N && s_rready[m_rid] && m_rlast) mdl_cnt[m_rid]--;
    if (g >= 0) begin
      mdl_valid = 1; mdl_addr = s_araddr[g]; mdl_len = s_arlen[g];
      mdl_size = s_arsize[g]; mdl_burst = s_arburst[g]; mdl_id = g;
      mdl_cnt[g]++;
      mdl_rr = (g + 1) % N;
    end else if (!mdl_valid || m_arready) begin
      mdl_valid = 0;
    end
    mdl_busy = busy_n;
  endtask

  task automatic sample(); #1; compare_all(); endtask
  task automatic tick();   @(posedge ap_clk); model_update(); #1; endtask
  task automatic cycle();  sample(); tick(); endtask

  task automatic set_ar(input int p, input logic [AW-1:0] addr, input logic [7:0] len);
    s_arvalid[p] = 1'b1; s_araddr[p] = addr; s_arlen[p] = len;
    s_arsize[p] = 3'd6; s_arburst[p] = AXI_BURST_INCR;
  endtask

  task automatic set_r(input int rid, input logic last, input logic [N-1:0] rr);
    m_rvalid = 1'b1; m_rid = IW'(rid); m_rlast = last; s_rready = rr;
    m_rdata = DW'($urandom); m_rresp = AXI_RESP_OKAY;
  endtask

  task automatic clr_r();
    m_rvalid = 1'b0; m_rid = '0; m_rlast = 1'b0; s_rready = '1;
  endtask

  task automatic drain(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      set_r(p, 1'b1, '1);
      cycle();
    end
    clr_r();
  endtask

  typedef struct {
    logic          rvalid;
    logic [IW-1:0] rid;
    logic [N-1:0]  rready;
    logic [N-1:0]  exp_rvalid;
    logic          exp_mrready;
  } r_vec_t;

  r_vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 4'd0, 4'b1111, 4'b0001, 1'b1};
    vecs[1] = '{1'b1, 4'd1, 4'b1101, 4'b0010, 1'b0};
    vecs[2] = '{1'b1, 4'd2, 4'b0100, 4'b0100, 1'b1};
    vecs[3] = '{1'b1, 4'd3, 4'b0111, 4'b1000, 1'b0};
    vecs[4] = '{1'b0, 4'd2, 4'b1111, 4'b0000, 1'b1};
    vecs[5] = '{1'b0, 4'd1, 4'b1101, 4'b0000, 1'b0};

    ap_rst_n = 1'b0;
    s_arvalid = '1; s_rready = '1; m_arready = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_araddr[i] = AW'(i * 'h100); s_arlen[i] = 8'(i); s_arsize[i] = 3'd6;
      s_arburst[i] = AXI_BURST_INCR;
    end
    m_rdata = '0; m_rresp = AXI_RESP_OKAY;
    clr_r();
    repeat (2) @(posedge ap_clk);
    #1;
    model_reset();

    // reset: requests present but nothing granted, outputs cleared
    sample();
    check("rst_arready", s_arready, 0);
    check("rst_arvalid", m_arvalid, 0);
    tick();
    ap_rst_n  = 1'b1;
    s_arvalid = '0;

    // single request from port 2, 8-beat burst back
    set_ar(2, 64'h1000, 8'd7);
    sample();
    check("single_grant", dut_grant(), 2);
    tick();
    s_arvalid = '0;
    sample();
    check("single_arvalid", m_arvalid, 1);
    check("single_arid", m_arid, 2);
    check("single_arlen", m_arlen, 7);
    check("single_araddr", m_araddr, 64'h1000);
    tick();
    m_arready = 1'b1;
    cycle();
    for (int b = 0; b < 8; b++) begin
      set_r(2, (b == 7), '1);
      sample();
      check("single_rvalid", s_rvalid, 4'b0100);
      tick();
    end
    clr_r();
    cycle();
    sample();
    check("single_busy_drop", busy, 0);
    tick();

    // fairness with all ports requesting; pointer starts at 3, cap of 2 each
    s_arvalid = '1;
    for (int k = 0; k < 10; k++) begin
      sample();
      check("fair_grant", dut_grant(), (k < 8) ? (3 + k) % 4 : -1);
      tick();
    end
    s_arvalid = '0;
    cycle();
    for (int p = 0; p < N; p++) drain(p, 2);
    cycle();

    // outstanding cap on port 0, port 1 still served
    set_ar(0, 64'hA000, 8'd1);
    sample(); check("cap_g0", dut_grant(), 0); tick();
    sample(); check("cap_g1", dut_grant(), 0); tick();
    set_ar(1, 64'hB000, 8'd2);
    sample(); check("cap_skip", dut_grant(), 1); tick();
    s_arvalid[1] = 1'b0;
    set_r(0, 1'b1, '1);
    sample(); check("cap_still", dut_grant(), -1); tick();
    clr_r();
    sample(); check("cap_release", dut_grant(), 0); tick();
    s_arvalid = '0;
    cycle();
    drain(0, 2);
    drain(1, 1);

    // AR backpressure: fields stable, no arready
    m_arready = 1'b0;
    set_ar(3, 64'h3300, 8'd3);
    sample(); check("bp_first", dut_grant(), 3); tick();
    for (int p = 0; p < N; p++) set_ar(p, AW'(64'hC000 + p), 8'd0);
    for (int k = 0; k < 5; k++) begin
      sample();
      check("bp_arready", s_arready, 0);
      check("bp_addr", m_araddr, 64'h3300);
      check("bp_id", m_arid, 3);
      tick();
    end
    m_arready = 1'b1;
    sample(); check("bp_resume", dut_grant(), 0); tick();
    s_arvalid = '0;
    cycle();
    // R backpressure from port 1
    set_r(1, 1'b0, 4'b1101);
    for (int k = 0; k < 2; k++) begin
      sample();
      check("bp_mrready", m_rready, 0);
      check("bp_rvalid", s_rvalid, 4'b0010);
      tick();
    end
    s_rready = '1;
    sample(); check("bp_delivered", m_rready, 1); tick();
    clr_r();
    drain(3, 1);
    drain(0, 1);

    // AR capture and final rlast for port 3 in the same cycle
    set_ar(3, 64'h7000, 8'd0);
    cycle();
    s_arvalid = '0;
    cycle();
    set_ar(3, 64'h7100, 8'd0);
    set_r(3, 1'b1, '1);
    sample(); check("sim_grant", dut_grant(), 3); tick();
    clr_r();
    sample(); check("sim_second", dut_grant(), 3); tick();
    sample(); check("sim_capped", dut_grant(), -1); tick();
    s_arvalid = '0;
    drain(3, 2);
    cycle();

    // R routing vectors
    for (int v = 0; v < 6; v++) begin
      m_rvalid = vecs[v].rvalid; m_rid = vecs[v].rid; m_rlast = 1'b0;
      s_rready = vecs[v].rready; m_rdata = DW'($urandom);
      sample();
      check($sformatf("tbl_rvalid[%0d]", v), s_rvalid, vecs[v].exp_rvalid);
      check($sformatf("tbl_mrready[%0d]", v), m_rready, vecs[v].exp_mrready);
      tick();
    end
    clr_r();

    // bad rid
    set_r(9, 1'b1, '0);
    sample();
    check("bad_rvalid", s_rvalid, 0);
    check("bad_mrready", m_rready, 1);
    tick();
    clr_r();
    sample(); check("bad_err", err, 1); tick();

    // reset in the middle of a burst
    m_arready = 1'b0;
    set_ar(0, 64'hD000, 8'd3);
    cycle();
    s_arvalid = '0;
    set_r(0, 1'b0, '1);
    cycle();
    sample(); check("pre_rst_busy", busy, 1); tick();
    ap_rst_n = 1'b0;
    cycle();
    ap_rst_n = 1'b1;
    clr_r();
    m_arready = 1'b1;
    sample();
    check("rst_mid_arvalid", m_arvalid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_err", err, 0);
    tick();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int rid;
      for (int p = 0; p < N; p++) begin
        s_arvalid[p] = ($urandom % 3) != 0;
        s_araddr[p]  = {$urandom, $urandom};
        s_arlen[p]   = 8'($urandom);
        s_arsize[p]  = 3'($urandom);
        s_arburst[p] = 2'($urandom);
      end
      m_arready = ($urandom % 4) != 0;
      s_rready  = N'($urandom) | N'($urandom);
      m_rdata   = DW'($urandom);
      m_rresp   = 2'($urandom);
      m_rvalid  = ($urandom % 2) != 0;
      rid = (($urandom % 64) == 0) ? N + int'($urandom % (16 - N)) : int'($urandom % N);
      m_rid = IW'(rid);
      if (rid < N) m_rlast = (mdl_cnt[rid] > 0) && (($urandom % 2) != 0);
      else         m_rlast = 1'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares one AXI4 read master port (`axi_bus_rd_t.master`) among `NUM_PORTS` read requesters (`axi_bus_rd_t.slave` each), such as the merge-tree leaf readers that fetch sorted runs from one HBM/DDR channel. AR requests are granted round-robin through a one-entry output register. Each granted request is tagged with the requester index on `arid`. R beats are routed back by `rid`. Per-requester outstanding-burst counters bound in-flight traffic and expose a busy/idle status to the kernel controller.

## Interface
- `NUM_PORTS`, 4: number of requesters; 2 ≤ `NUM_PORTS` ≤ 2**`M_AXI_ID_WIDTH`.
- `M_AXI_ADDR_WIDTH`, 64: address width, same on all ports.
- `M_AXI_DATA_WIDTH`, 512: data width, same on all ports.
- `M_AXI_ID_WIDTH`, 4: ID width, same on all ports.
- `MAX_OUTSTANDING`, 16: maximum accepted-but-incomplete bursts per requester.
- `ap_clk`  in  1  sole clock; all logic is rising-edge.
- `ap_rst_n`  in  1  synchronous, active-low reset.
- `s_axi[NUM_PORTS]`  slave modport  `axi_bus_rd_t`  requester ports; requester `arid` is ignored.
- `m_axi`  master modport  `axi_bus_rd_t`  shared memory port.
- `busy`  out  1  registered; 1 while `m_axi.arvalid` is high or any outstanding counter is nonzero.
- `err_bad_rid`  out  1  sticky; set when an R beat arrives with `rid` ≥ `NUM_PORTS`.

## Operation
- **AR output register.** Holds `araddr`, `arburst`, `arlen`, `arsize`, `arid`, and `arvalid`. It can load when `!m_axi.arvalid || m_axi.arready`, so back-to-back grants run at full rate.
- **Eligibility.** Port i is eligible when `s_axi[i].arvalid` is high and `cnt[i] < MAX_OUTSTANDING`.
- **Grant.** The winner is the first eligible port at or after `rr_ptr`, searching upward with wrap. When the register can load and some port is eligible:
  - assert `s_axi[g].arready` (combinational, this cycle only); all other `arready` stay 0;
  - load the register with g's fields and `arid = g`;
  - set `rr_ptr = (g+1) mod NUM_PORTS`.
- **No grant.** When no port is eligible or the register cannot load, all `arready` are 0 and `rr_ptr` is held.
- **Counters.** `cnt[i]` is `$clog2(MAX_OUTSTANDING+1)` bits wide.
  - +1 on the cycle port i's AR is captured into the register.
  - −1 on an R handshake with `rlast` set and `rid == i`.
  - Both in the same cycle: the count is unchanged.
  - The count never wraps; eligibility gating guarantees this.
- **R routing.** This path is combinational.
  - `s_axi[i].rvalid = m_axi.rvalid && rid == i`.
  - `m_axi.rready = s_axi[rid].rready`.
  - `rdata`, `rresp`, and `rlast` go to every port unchanged; `s_axi[i].rid = 0`.
  - Bad `rid` (≥ `NUM_PORTS`): `m_axi.rready = 1`, the beat is dropped, `err_bad_rid` is set, and no counter changes.
- **Reset.** `m_axi.arvalid` = 0, all AR fields = 0, `rr_ptr` = 0, all `cnt` = 0, `busy` = 0, `err_bad_rid` = 0. `s_axi[*].arready` = 0 during reset. In-flight bursts are discarded, so the memory side must be reset together with this block.

## Timing
- AR latency is 1 cycle: an `s_axi` AR handshake at cycle N gives `m_axi.arvalid` = 1 at N+1.
- `m_axi` AR fields are stable while `arvalid` is high and `arready` is low.
- Sustained throughput is 1 AR grant per cycle.
- R has 0 latency; backpressure from the addressed requester passes straight through to `m_axi.rready`.
- A requester at `MAX_OUTSTANDING` is skipped without blocking the others. It becomes eligible the cycle after its completing `rlast` handshake.
- `busy` reflects state one cycle late, because it is registered.
- `arready` never depends on the same requester's `arvalid` except through eligibility. No combinational path runs from `m_axi.arready` into the grant beyond the load condition.

## Structure
- Package `axi_arb_pkg` holds:
  - localparam functions: `port_idx_w(NUM_PORTS)` = `$clog2(NUM_PORTS)` and counter width;
  - AXI constants `AXI_BURST_INCR = 2'b01` and `AXI_RESP_OKAY = 2'b00`.
- Sub-module `rr_arbiter`:
  - parameterised on `NUM_PORTS`;
  - inputs: request vector and advance enable; outputs: one-hot grant and binary grant index;
  - owns `rr_ptr`, with synchronous active-low reset on `ap_clk`/`ap_rst_n`.
- Top level holds the AR register, the counters, R routing, and the status outputs.

## Test plan
- **Single request.** Port 2 issues AR `araddr=0x1000`, `arlen=7`. Expect `m_axi` `arvalid` at N+1 with `arid=2`, `arlen=7`. Return 8 beats with `rid=2`: only `s_axi[2]` sees `rvalid`, `cnt[2]` goes 0→1→0, and `busy` drops.
- **Fairness.** All 4 ports hold `arvalid` continuously with `m_axi.arready=1`. Grants follow 0,1,2,3,0,… at one per cycle, and no port waits more than 4 cycles.
- **Outstanding cap.** With `MAX_OUTSTANDING=2`, port 0 issues 3 ARs and no R returns. Expect 2 grants, then port 0 is stalled while port 1 is still granted. One `rlast` for `rid=0` releases port 0 on the next cycle.
- **Backpressure.** Hold `m_axi.arready=0` for 5 cycles. AR fields stay stable and all `s_axi` `arready` stay 0. During an R burst, `s_axi[1].rready=0` forces `m_axi.rready=0`, and the beat is delivered once `rready` rises.
- **Simultaneous events.** Capture port 3's AR in the same cycle as port 3's final `rlast`. `cnt[3]` is unchanged.
- **Bad ID and reset.** An R beat with `rid=9` sets `err_bad_rid`, is accepted, and no port sees `rvalid`. Asserting `ap_rst_n=0` mid-burst clears `arvalid`, the counters, `busy`, and `err` on the next edge.
